// File: rtl/game_flow_ctl.sv
// Game sequencer: IDLE/RESET/PLAY/OVER flow, paced movement tick with a
// level-dependent period, and the saturating score for the overlay.
module game_flow_ctl #(
    parameter int BASE_DIV    = 400_000,
    parameter int DIV_STEP    = 40_000,
    parameter int LEVEL_STEPS = 256,
    parameter int MAX_LEVEL   = 7,
    parameter int RST_CYCLES  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        pause,
    input  logic        endgame,
    output logic        move_en,
    output logic        rect_rst,
    output logic [1:0]  game_state,
    output logic [2:0]  level,
    output logic [11:0] score
);

    localparam int DIV_W  = (BASE_DIV > 1)    ? $clog2(BASE_DIV)    : 1;
    localparam int STEP_W = (LEVEL_STEPS > 1) ? $clog2(LEVEL_STEPS) : 1;
    localparam int RST_W  = (RST_CYCLES > 1)  ? $clog2(RST_CYCLES)  : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RESET = 2'd1,
        S_PLAY  = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_start_q;
    logic [RST_W-1:0]    r_rst_cnt;
    logic [DIV_W-1:0]    r_div;
    logic [STEP_W-1:0]   r_step;
    logic [2:0]          r_level;
    logic [11:0]         r_score;
    logic                r_move_en;
    logic                r_rect_rst;

    logic                w_start_rise;
    logic                w_enter_reset;
    logic [DIV_W-1:0]    w_div_last;
    logic                w_wrap;
    logic                w_step_last;
    logic                w_level_max;
    logic                w_rst_last;

    assign w_start_rise  = start & ~r_start_q;
    assign w_enter_reset = w_start_rise && ((r_state == S_IDLE) || (r_state == S_OVER));

    // Period shrinks with level; the parameter constraint keeps this positive.
    assign w_div_last  = DIV_W'(BASE_DIV - 1 - int'(r_level) * DIV_STEP);
    assign w_wrap      = (r_div == w_div_last);
    assign w_step_last = (r_step == STEP_W'(LEVEL_STEPS - 1));
    assign w_level_max = (r_level == 3'(MAX_LEVEL));
    assign w_rst_last  = (r_rst_cnt == RST_W'(RST_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_start_q  <= 1'b0;
            r_rst_cnt  <= '0;
            r_div      <= '0;
            r_step     <= '0;
            r_level    <= '0;
            r_score    <= '0;
            r_move_en  <= 1'b0;
            r_rect_rst <= 1'b1;
        end else begin
            r_start_q <= start;
            r_move_en <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_rect_rst <= 1'b1;
                end
                S_RESET: begin
                    r_rect_rst <= 1'b1;
                    if (w_rst_last) begin
                        r_state    <= S_PLAY;
                        r_rect_rst <= 1'b0;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + 1'b1;
                    end
                end
                S_PLAY: begin
                    r_rect_rst <= 1'b0;
                    // endgame outranks both pause and a divider wrap in the same cycle
                    if (endgame) begin
                        r_state <= S_OVER;
                    end else if (!pause) begin
                        if (w_wrap) begin
                            r_div     <= '0;
                            r_move_en <= 1'b1;
                            if (r_score != 12'hFFF) begin
                                r_score <= r_score + 1'b1;
                            end
                            if (w_step_last) begin
                                r_step <= '0;
                                if (!w_level_max) begin
                                    r_level <= r_level + 1'b1;
                                end
                            end else begin
                                r_step <= r_step + 1'b1;
                            end
                        end else begin
                            r_div <= r_div + 1'b1;
                        end
                    end
                end
                S_OVER: begin
                    r_rect_rst <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // A new game starts from a clean slate whether coming from IDLE or OVER
            if (w_enter_reset) begin
                r_state    <= S_RESET;
                r_rect_rst <= 1'b1;
                r_rst_cnt  <= '0;
                r_div      <= '0;
                r_step     <= '0;
                r_level    <= '0;
                r_score    <= '0;
            end
        end
    end

    assign move_en    = r_move_en;
    assign rect_rst   = r_rect_rst;
    assign game_state = r_state;
    assign level      = r_level;
    assign score      = r_score;

endmodule

// File: doc/game_flow_ctl.md
# game_flow_ctl

Top-level game sequencer for the falling-rectangle game. It owns the IDLE/PLAY/OVER flow and holds the rectangle controller in reset between games. During play it issues the one-cycle movement tick (`move_en`) that paces the rectangle controller, raising the speed level as the game progresses. It also keeps the score shown by the overlay.

## Interface
Parameters:
- `BASE_DIV`, 400_000: tick period at level 0, in clk cycles (100 Hz at 40 MHz).
- `DIV_STEP`, 40_000: period reduction per level; must satisfy `BASE_DIV > MAX_LEVEL*DIV_STEP`.
- `LEVEL_STEPS`, 256: `move_en` ticks per level increment.
- `MAX_LEVEL`, 7: level saturation value.
- `RST_CYCLES`, 4: length of the `rect_rst` pulse in RESET state.

Ports:
- `clk`, in, 1: 40 MHz system clock.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: start/restart button, already synchronised and debounced; level signal, rising edge used.
- `pause`, in, 1: level; freezes play while high.
- `endgame`, in, 1: from the rectangle controller; rectangle reached bottom.
- `move_en`, out, 1: one-cycle movement tick to the rectangle controller.
- `rect_rst`, out, 1: reset to the rectangle controller.
- `game_state`, out, 2: IDLE=0, RESET=1, PLAY=2, OVER=3.
- `level`, out, 3: current speed level.
- `score`, out, 12: ticks survived, saturating at 4095.

## Operation
- Start edge: `start_q` is registered; `start_rise = start & ~start_q`. This is the only start event used.
- IDLE:
  - `rect_rst`=1, `move_en`=0.
  - `start_rise` moves to RESET.
- RESET:
  - `rect_rst`=1 for exactly `RST_CYCLES` cycles.
  - On entry, `score`, `level`, the step counter and the divider are cleared.
  - `endgame` is ignored (stale while the rectangle controller is in reset).
  - Then moves to PLAY.
- PLAY:
  - `rect_rst`=0.
  - The divider counts 0..P-1, with P = `BASE_DIV - level*DIV_STEP`. At P-1 it wraps to 0 and `move_en` pulses for one cycle.
  - Each `move_en`:
    - `score` increments, saturating at 4095.
    - The step counter increments. At `LEVEL_STEPS-1` it wraps and `level` increments, saturating at `MAX_LEVEL`.
  - A new P applies from the next divider period.
  - `pause`=1: the divider and counters hold, and `move_en`=0.
  - `endgame`=1 moves to OVER next cycle. `move_en` is forced 0 in any cycle where `endgame`=1, even if the divider wraps in that cycle.
  - `start_rise` is ignored.
- OVER:
  - `rect_rst`=0 so the rectangle stays visible at its final position.
  - `move_en`=0; `score` and `level` are held.
  - `start_rise` moves to RESET.
- `pause` has no effect outside PLAY.

## Timing
- Reset values: state=IDLE, `rect_rst`=1, `move_en`=0, `level`=0, `score`=0, divider=0, step counter=0, `start_q`=0.
- All outputs are registered.
- `rst` mid-game returns to the reset values on the next edge and overrides every other input.
- State transition latency is one cycle after the qualifying input is sampled.
- Start to play:
  - `start_rise` sampled at edge N: `game_state`=RESET from N+1.
  - `rect_rst`=1 for cycles N+1..N+RST_CYCLES.
  - PLAY from N+RST_CYCLES+1.
  - First `move_en` occurs P cycles after PLAY is entered: the divider starts at 0 and pulses when its count is P-1.
- Holding `start` high produces exactly one restart; a new restart needs a release and a press.
- End of game: `endgame` sampled high at edge M gives `game_state`=OVER from M+1, and no `move_en` is asserted at M or later.
- Simultaneous `pause` and `endgame` in PLAY: `endgame` wins and the block goes to OVER.
- Divider width: enough bits for `BASE_DIV-1`. Level/period arithmetic is unsigned and never underflows, given the parameter constraint.

## Test plan
All scenarios use `BASE_DIV`=10, `DIV_STEP`=2, `LEVEL_STEPS`=4, `MAX_LEVEL`=3, `RST_CYCLES`=4.
- Reset then idle: hold `rst` 3 cycles, release, wait 50 cycles → state=0, `rect_rst`=1, `move_en`=0, `score`=0.
- Start sequence: pulse `start` 1 cycle → RESET for exactly 4 cycles with `rect_rst`=1, then PLAY; first `move_en` 10 cycles after PLAY entry, then every 10 cycles; `score`=1,2,3.
- Level ramp: run 4 ticks → `level`=1 and the next gap is 8 cycles. Continue to 12 ticks → `level`=3 with 4-cycle gaps; a further 8 ticks leave `level`=3.
- Pause: assert `pause` 25 cycles mid-period → no `move_en`, score held; after release the remaining divider count completes.
- Endgame: assert `endgame` in the same cycle the divider wraps → no `move_en`, OVER next cycle, score frozen. Holding `start` from before OVER causes no restart; a fresh press → RESET with score=0, level=0.
- Mid-game reset: assert `rst` during PLAY at level 2 → next cycle state=IDLE, `rect_rst`=1, `level`=0, `score`=0.
